// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the sequential magnitude comparator.
package cmp_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Counter must hold 1..ndig inclusive.
  function automatic int cnt_width(input int ndig);
    return $clog2(ndig + 1);
  endfunction

endpackage

// File: rtl/comparator_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice; equality is neither gt nor lt.
module comparator_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             gt,
  output logic             lt
);

  assign gt = (x > y);
  assign lt = (x < y);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, early exit on first difference.
//
// state | meaning
// IDLE  | waiting for start; flags hold last result
// SCAN  | comparing top digit of sa/sb, shifting left while equal
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(NDIG);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sb_q;
  logic [CNT_W-1:0] dig_cnt_q;
  logic             dig_gt, dig_lt;
  logic             load, shift, done_ne, done_eq;

  comparator_digit #(.DIGIT(DIGIT)) u_digit (
    .x  (sa_q[WIDTH-1 -: DIGIT]),
    .y  (sb_q[WIDTH-1 -: DIGIT]),
    .gt (dig_gt),
    .lt (dig_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (done_ne || done_eq) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load    = 1'b0;
    shift   = 1'b0;
    done_ne = 1'b0;
    done_eq = 1'b0;
    case (state_q)
      IDLE: load = start;
      SCAN: begin
        if (dig_gt || dig_lt)          done_ne = 1'b1;
        else if (dig_cnt_q == CNT_LAST) done_eq = 1'b1;
        else                           shift   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q      <= '0;
      sb_q      <= '0;
      dig_cnt_q <= '0;
      valid     <= 1'b0;
      a_gt_b    <= 1'b0;
      a_lt_b    <= 1'b0;
      a_eq_b    <= 1'b0;
    end else begin
      valid <= done_ne | done_eq;
      if (load) begin
        sa_q      <= signed_mode ? (a ^ SIGN_MASK) : a;
        sb_q      <= signed_mode ? (b ^ SIGN_MASK) : b;
        dig_cnt_q <= CNT_ONE;
      end else if (shift) begin
        sa_q      <= sa_q << DIGIT;
        sb_q      <= sb_q << DIGIT;
        dig_cnt_q <= dig_cnt_q + CNT_ONE;
      end
      if (done_ne) begin
        a_gt_b <= dig_gt;
        a_lt_b <= dig_lt;
        a_eq_b <= 1'b0;
      end else if (done_eq) begin
        a_gt_b <= 1'b0;
        a_lt_b <= 1'b0;
        a_eq_b <= 1'b1;
      end
    end
  end

  assign busy = (state_q == SCAN);

endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Parametrised, multi-cycle magnitude comparator and the successor to the combinational 2-bit comparator. It compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, and stops at the first digit that differs. It supports signed and unsigned modes through a start/busy/valid handshake. It is a reusable compare engine for control and datapath blocks where wide operands make a single-cycle compare too costly in area or timing.

## Interface
- WIDTH, 8, operand width in bits; must be ≥ 2 and a multiple of DIGIT.
- DIGIT, 2, bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH. NDIG = WIDTH/DIGIT.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy = 0.
- signed_mode  in  1  1 = two's-complement compare; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  compare in progress.
- valid  out  1  one-cycle pulse; result flags updated this cycle.
- a_gt_b  out  1  A > B, registered.
- a_lt_b  out  1  A < B, registered.
- a_eq_b  out  1  A = B, registered.

## Operation
- Reset (async assert, sync release): state IDLE, busy = 0, valid = 0, all three flags = 0, internal shift registers and digit counter = 0.
- IDLE, start = 1: capture a and b into shift registers sa and sb. If signed_mode = 1, invert the MSB of both captured values (sign-bias trick) so the same unsigned compare applies. Set digit counter = 1, busy = 1, go to SCAN.
- SCAN: compare the top DIGIT bits of sa and sb.
  - Digits differ: set a_gt_b/a_lt_b from the digit compare, a_eq_b = 0, valid = 1, busy = 0, go to IDLE.
  - Digits equal and counter = NDIG: a_eq_b = 1, other flags = 0, valid = 1, busy = 0, go to IDLE.
  - Digits equal otherwise: shift sa and sb left by DIGIT, increment the counter, stay in SCAN.
- start while busy = 1 is ignored. Operands and mode are not re-sampled.
- Flags hold their last result until the next valid. After the first valid, exactly one flag is high.
- Reset during SCAN aborts the compare. No valid is produced and the flags clear to 0.

## Timing
- start is sampled at edge E0. The result of digit k is registered at edge Ek.
- If the first differing digit is k (1..NDIG), flags and valid are set at Ek and busy falls at Ek. Latency is k cycles.
- Equal operands take NDIG cycles (the worst case).
- valid is high for exactly one cycle. A start during the valid cycle is accepted, giving back-to-back throughput of one compare per k+1 cycles.
- busy rises at E0 and is never high in the same cycle as valid.
- No combinational path from inputs to outputs.

## Structure
- Package cmp_pkg holds the state typedef (IDLE, SCAN) and the helper function computing the counter width, clog2(NDIG+1).
- Sub-module comparator_digit #(DIGIT): combinational, inputs x/y [DIGIT-1:0], outputs gt/lt, equality = neither. It is instantiated once on the top digit of sa/sb.
- Top level contains the FSM, shift registers, counter and output registers.

## Test plan
Defaults WIDTH = 8, DIGIT = 2 unless stated.
- a = 8'hA5, b = 8'hA5, unsigned -> a_eq_b = 1, valid 4 cycles after start, busy high for 4 cycles.
- a = 8'h80, b = 8'h7F -> unsigned: a_gt_b = 1 at latency 1. Signed: a_lt_b = 1 at latency 1.
- a = 8'h1C, b = 8'h18 -> a_gt_b at latency 3. a = 8'h34, b = 8'h37 -> a_lt_b at latency 4.
- Handshake checks:
  - start held high throughout, with a changed mid-compare -> the result reflects the first operands only.
  - Next compare starts the cycle after valid.
- Reset mid-operation: rst_n pulsed low at cycle 2 of an 8'h00 vs 8'h01 compare -> immediately busy = 0 and flags = 0, with no valid. A new compare afterwards is correct.
- Exhaustive sweep at WIDTH = 4, DIGIT = 1 and at WIDTH = 4, DIGIT = 4: all 256 pairs in both modes, checked against a behavioural model. Check flags are one-hot and latency equals the index of the first differing digit.
